// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode feeding the ALU through a registered two-entry skid buffer.
// Optional macro ALU_ISSUE_ILLEGAL_EN: issue unsupported encodings as flagged entries instead of dropping them.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_ctrl,
    output logic [31:0] out_op1,
    output logic [31:0] out_op2,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal
);

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_ctrl_e;

    typedef struct packed {
        alu_ctrl_e   ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
    } entry_t;

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic       w_f7_zero;
    logic       w_f7_alt;
    logic       w_legal;
    entry_t     w_dec;

    assign w_opcode  = in_insn[6:0];
    assign w_f3      = in_insn[14:12];
    assign w_f7_zero = (in_insn[31:25] == 7'b0000000);
    assign w_f7_alt  = (in_insn[31:25] == 7'b0100000);

    always_comb begin
        w_dec      = '0;
        w_dec.ctrl = ALU_ADD;
        w_dec.rd   = in_insn[11:7];
        w_legal    = 1'b1;
        case (w_opcode)
            7'b0110011, 7'b0010011: begin
                w_dec.op1 = in_rs1_val;
                if (w_opcode == 7'b0110011)
                    w_dec.op2 = in_rs2_val;
                else if (w_f3 == 3'b001 || w_f3 == 3'b101)
                    w_dec.op2 = {27'b0, in_insn[24:20]};
                else
                    w_dec.op2 = {{20{in_insn[31]}}, in_insn[31:20]};
                // OP checks funct7 on every funct3; OP-IMM only on the shift forms.
                case (w_f3)
                    3'b000: begin
                        if (w_opcode == 7'b0110011) begin
                            w_dec.ctrl = w_f7_alt ? ALU_SUB : ALU_ADD;
                            w_legal    = w_f7_zero || w_f7_alt;
                        end else begin
                            w_dec.ctrl = ALU_ADD;
                        end
                    end
                    3'b001: begin
                        w_dec.ctrl = ALU_SLL;
                        w_legal    = w_f7_zero;
                    end
                    3'b101: begin
                        w_dec.ctrl = w_f7_alt ? ALU_SRA : ALU_SRL;
                        w_legal    = w_f7_zero || w_f7_alt;
                    end
                    3'b010: w_dec.ctrl = ALU_SLT;
                    3'b011: w_dec.ctrl = ALU_SLTU;
                    3'b100: w_dec.ctrl = ALU_XOR;
                    3'b110: w_dec.ctrl = ALU_OR;
                    default: w_dec.ctrl = ALU_AND;
                endcase
                if (w_opcode == 7'b0110011 && !(w_f3 == 3'b000 || w_f3 == 3'b101))
                    w_legal = w_f7_zero;
            end
            7'b0110111: begin
                w_dec.ctrl = ALU_LUI;
                w_dec.op2  = {in_insn[31:12], 12'b0};
            end
            7'b0010111: begin
                w_dec.ctrl = ALU_ADD;
                w_dec.op1  = in_pc;
                w_dec.op2  = {in_insn[31:12], 12'b0};
            end
            default: w_legal = 1'b0;
        endcase
        w_dec.we = w_legal && (in_insn[11:7] != 5'd0);
        if (!w_legal) begin
            w_dec.ctrl = ALU_ADD;
            w_dec.op1  = '0;
            w_dec.op2  = '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            w_dec.illegal = 1'b1;
`endif
        end
    end

    entry_t r_main;
    entry_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;
    logic   r_in_ready;

    logic w_take;
    logic w_main_free;
    logic w_main_from_skid;
    logic w_main_from_in;
    logic w_skid_load;
    logic w_main_valid_nxt;
    logic w_skid_valid_nxt;

`ifdef ALU_ISSUE_ILLEGAL_EN
    assign w_take = in_valid && r_in_ready;
`else
    assign w_take = in_valid && r_in_ready && w_legal;
`endif

    assign w_main_free = !r_main_valid || out_ready;

    always_comb begin
        w_main_from_skid = 1'b0;
        w_main_from_in   = 1'b0;
        w_skid_load      = 1'b0;
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                w_main_from_skid = 1'b1;
                w_main_valid_nxt = 1'b1;
                w_skid_load      = w_take;
                w_skid_valid_nxt = w_take;
            end else begin
                w_main_from_in   = w_take;
                w_main_valid_nxt = w_take;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (w_take) begin
            w_skid_load      = 1'b1;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
            if (w_main_from_skid)
                r_main <= r_skid;
            else if (w_main_from_in)
                r_main <= w_dec;
            if (w_skid_load)
                r_skid <= w_dec;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_main_valid;
    assign out_alu_ctrl = r_main.ctrl;
    assign out_op1      = r_main.op1;
    assign out_op2      = r_main.op2;
    assign out_rd       = r_main.rd;
    assign out_we       = r_main.we;
    assign out_illegal  = r_main.illegal;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue stage that feeds the RISC-V core's combinational ALU. Accepts one instruction per cycle with its PC and register-file read values. Decodes RV32I register-register, register-immediate, LUI and AUIPC forms into the 4-bit ALU control code and the two 32-bit operands. Presents the result through a registered valid/ready output with a two-entry skid buffer, so the execute side can stall without a combinational ready path back to fetch/decode.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; discards all buffered entries.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: stage can accept. Registered.
- `in_insn` in 32: instruction word.
- `in_pc` in 32: instruction address.
- `in_rs1_val` in 32: register rs1 value.
- `in_rs2_val` in 32: register rs2 value.
- `out_valid` out 1: issue entry present.
- `out_ready` in 1: execute side accepts.
- `out_alu_ctrl` out 4: ALU control code. SLL=0, SRL=1, SRA=2, ADD=3, SUB=4, XOR=5, OR=6, AND=7, SLT=8, SLTU=9, LUI=10.
- `out_op1` out 32: ALU Operand1.
- `out_op2` out 32: ALU Operand2.
- `out_rd` out 5: destination register, insn[11:7].
- `out_we` out 1: register write enable; 1 when rd≠0 and the instruction is legal.
- `out_illegal` out 1: unsupported encoding flag.

## Operation
- **OP (0110011):** op1=rs1_val, op2=rs2_val. funct3 maps as follows:
  - 000: ADD when funct7=0000000, SUB when funct7=0100000.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRL when funct7=0000000, SRA when funct7=0100000.
  - 110: OR. 111: AND.
  - Any other funct7 is unsupported.
- **OP-IMM (0010011):** op1=rs1_val, op2=sign-extended insn[31:20]. funct3 maps as for OP, with ADD for 000.
  - Shift forms (001, 101): op2={27'b0, insn[24:20]}.
  - SLLI requires funct7=0000000. SRLI/SRAI require funct7=0000000/0100000.
- **LUI (0110111):** ctrl=LUI, op1=0, op2={insn[31:12],12'b0}.
- **AUIPC (0010111):** ctrl=ADD, op1=in_pc, op2={insn[31:12],12'b0}.
- **Unsupported encodings:** every other opcode, or a bad funct7, is handled per Configuration.
- **Storage:** two entries, main (drives the outputs) and skid.
- **Input transfer:** occurs when in_valid && in_ready. Decode is combinational on the inputs and the decoded result is stored.
- **Entry movement on each edge:**
  - If main is empty or the output transfers (out_valid && out_ready): main loads skid if skid is valid, otherwise the new input.
  - If the skid was loaded into main, the new input (if any) goes to the skid.
  - If main stays occupied and not consumed, the new input goes to the skid.
- **in_ready:** next value = !skid_valid_next.
- **flush:** clears both valid bits and sets in_ready=1 on the next edge. A simultaneous input transfer is discarded. flush has priority over every other event.
- **Reset values:** out_valid=0, in_ready=1, out_alu_ctrl=0, out_op1=0, out_op2=0, out_rd=0, out_we=0, out_illegal=0, skid empty.
- **Reset mid-operation:** all buffered entries are lost.

## Timing
- Latency: an input accepted at edge N appears on the outputs after edge N, with out_valid=1 in cycle N+1.
- Throughput: one instruction per cycle while out_ready=1.
- **Stall:** with out_ready=0, main holds. One further input is absorbed into the skid, and in_ready falls after that edge.
- **Release:** out_ready=1 with skid full moves skid to main and raises in_ready on the same edge. No bubble is inserted.
- **Output stability:** while out_valid=1 and out_ready=0, all out_* signals are stable.
- No combinational path exists from out_ready to in_ready.

## Configuration
- `ALU_ISSUE_ILLEGAL_EN` defined:
  - An unsupported encoding is accepted and issued as an entry with out_illegal=1, ctrl=ADD, op1=op2=0, out_we=0.
  - Its ordering relative to neighbouring entries is preserved.
- `ALU_ISSUE_ILLEGAL_EN` undefined:
  - An unsupported encoding is accepted (in_ready semantics unchanged) and dropped; no output entry is produced.
  - out_illegal is tied to 0.

## Test plan
- **SUB:** in_insn=0x40B50533, rs1=10, rs2=3 -> next cycle out_valid=1, ctrl=4, op1=10, op2=3, rd=10, we=1.
- **SRAI:** in_insn=0x40335293, rs1=0x80000000 -> ctrl=2, op2=3, rd=5.
- **ADDI:** in_insn=0xFFF00113 -> ctrl=3, op2=0xFFFFFFFF, rd=2.
- **LUI:** in_insn=0x123450B7 -> ctrl=10, op1=0, op2=0x12345000.
- **Back-pressure:**
  - Stream 4 instructions with out_ready=0 -> first in main, second in skid, in_ready=0 after the 2nd accept.
  - Raise out_ready -> all 4 issued in order with no bubble.
  - flush while full -> out_valid=0 and in_ready=1 next cycle.
- **Illegal encoding:** in_insn=0x0000007F.
  - With macro: out_illegal=1, we=0.
  - Without macro: no out_valid pulse, and the next legal instruction issues normally.
- **Reset:** assert rst_n=0 with both entries full -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
